// File: rtl/uart_pkg.sv
// Shared constants, register map and state encodings for the UART peripheral.
package uart_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int unsigned TX_FULL_BIT    = 0;
  localparam int unsigned TX_EMPTY_BIT   = 1;
  localparam int unsigned RX_VALID_BIT   = 2;
  localparam int unsigned RX_OVERRUN_BIT = 3;
  localparam int unsigned FRAME_ERR_BIT  = 4;
  localparam int unsigned TX_DROP_BIT    = 5;
  localparam int unsigned BUSY_BIT       = 9;
  localparam int unsigned TX_COUNT_LSB   = 16;
  localparam int unsigned RX_COUNT_LSB   = 24;

  localparam int unsigned DIV_W = 16;
  localparam logic [DIV_W-1:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Divisors below DIV_MIN would give zero-length bits or no mid-bit point.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop and a push in the same cycle both succeed even when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata_c = mem[rd_ptr];
  assign count_n = count + CW'(do_push) - CW'(do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      empty <= (count_n == '0);
      full  <= (count_n == CW'(DEPTH));
    end
  end

  // Storage carries no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, sticky error flags and irq.
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD_RATE   = 1_000_000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] DIV0 = DIV_W'(CLK_FREQ_HZ / BAUD_RATE);

  logic wr_en, rd_en, wr_data, wr_status, rd_data;
  logic [DIV_W-1:0] divisor;
  logic [1:0] ctrl;
  logic tx_drop, rx_overrun, frame_err;
  logic [31:0] status_c, rdata_c;
  logic unused_wdata;

  logic tx_full, tx_empty, tx_pop_c;
  logic [TX_CW-1:0] tx_count;
  logic [DATA_BITS-1:0] tx_head_c;
  logic rx_full, rx_empty, rx_pop_c, rx_push_c, frame_err_c;
  logic [RX_CW-1:0] rx_count;
  logic [DATA_BITS-1:0] rx_head_c;

  tx_state_e tx_state, tx_state_n;
  logic [DIV_W-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [BIT_W-1:0] tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic tx_line_c, tx_last_c;

  rx_state_e rx_state, rx_state_n;
  logic [DIV_W-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [BIT_W-1:0] rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
  logic rxd_meta, rxd_sync, rxd_prev;

  assign wr_en     = sel && (|mem_wmask);
  assign rd_en     = sel && mem_rstrb;
  assign wr_data   = wr_en && (reg_addr == REG_DATA);
  assign wr_status = wr_en && (reg_addr == REG_STATUS);
  assign rd_data   = rd_en && (reg_addr == REG_DATA);
  assign rx_pop_c  = rd_data && !rx_empty;
  assign unused_wdata = ^mem_wdata[31:DIV_W];

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(wr_data && !tx_full),
    .wdata(mem_wdata[DATA_BITS-1:0]), .pop(tx_pop_c), .rdata_c(tx_head_c),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push_c), .wdata(rx_shift),
    .pop(rx_pop_c), .rdata_c(rx_head_c),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Register file, sticky flags (set wins over clear), read data and irq.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      divisor    <= DIV0;
      ctrl       <= '0;
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      mem_rdata  <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_en && reg_addr == REG_DIVISOR) divisor <= clamp_div(mem_wdata[DIV_W-1:0]);
      if (wr_en && reg_addr == REG_CTRL)    ctrl    <= mem_wdata[1:0];
      tx_drop    <= (tx_drop & ~(wr_status & mem_wdata[TX_DROP_BIT])) | (wr_data & tx_full);
      rx_overrun <= (rx_overrun & ~(wr_status & mem_wdata[RX_OVERRUN_BIT]))
                  | (rx_push_c & rx_full & ~rx_pop_c);
      frame_err  <= (frame_err & ~(wr_status & mem_wdata[FRAME_ERR_BIT])) | frame_err_c;
      if (rd_en) mem_rdata <= rdata_c;
      irq <= (~rx_empty & ctrl[0]) | (tx_empty & ctrl[1]);
    end
  end

  always_comb begin
    status_c = '0;
    status_c[TX_FULL_BIT]    = tx_full;
    status_c[TX_EMPTY_BIT]   = tx_empty;
    status_c[RX_VALID_BIT]   = ~rx_empty;
    status_c[RX_OVERRUN_BIT] = rx_overrun;
    status_c[FRAME_ERR_BIT]  = frame_err;
    status_c[TX_DROP_BIT]    = tx_drop;
    status_c[BUSY_BIT]       = ~tx_empty | (tx_state != TX_IDLE);
    status_c[TX_COUNT_LSB +: 8] = 8'(tx_count);
    status_c[RX_COUNT_LSB +: 8] = 8'(rx_count);
    case (reg_addr)
      REG_DATA:    rdata_c = rx_empty ? 32'd0 : 32'(rx_head_c);
      REG_STATUS:  rdata_c = status_c;
      REG_DIVISOR: rdata_c = 32'(divisor);
      default:     rdata_c = 32'(ctrl);
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= tx_line_c;
    end
  end

  // Transmitter: divisor is latched per frame; STOP chains straight into START.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_div_n   = tx_div;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop_c   = 1'b0;
    tx_line_c  = 1'b1;
    tx_last_c  = (tx_cnt == tx_div - 16'd1);
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (!tx_empty) begin
          tx_pop_c = 1'b1; tx_state_n = TX_START; tx_shift_n = tx_head_c; tx_div_n = divisor;
        end
      end
      TX_START: begin
        tx_line_c = 1'b0;
        if (tx_last_c) begin tx_state_n = TX_DATA; tx_cnt_n = '0; tx_bit_n = '0; end
      end
      TX_DATA: begin
        tx_line_c = tx_shift[0];
        if (tx_last_c) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift >> 1;
          tx_bit_n   = tx_bit + BIT_W'(1);
          if (tx_bit == LAST_BIT) tx_state_n = TX_STOP;
        end
      end
      default: begin
        if (tx_last_c) begin
          tx_cnt_n = '0;
          if (!tx_empty) begin
            tx_pop_c = 1'b1; tx_state_n = TX_START; tx_shift_n = tx_head_c; tx_div_n = divisor;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIV0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Receiver: mid-bit sampling; a high line at the start midpoint is a glitch.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 16'd1;
    rx_div_n    = rx_div;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_push_c   = 1'b0;
    frame_err_c = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rxd_prev && !rxd_sync) begin rx_state_n = RX_START; rx_div_n = divisor; end
      end
      RX_START: begin
        if (rx_cnt == (rx_div >> 1) - 16'd1) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_state_n = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == rx_div - 16'd1) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rxd_sync, rx_shift[DATA_BITS-1:1]};
          rx_bit_n   = rx_bit + BIT_W'(1);
          if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
        end
      end
      default: begin
        if (rx_cnt == rx_div - 16'd1) begin
          rx_cnt_n    = '0;
          rx_state_n  = RX_IDLE;
          rx_push_c   = rxd_sync;
          frame_err_c = ~rxd_sync;
        end
      end
    endcase
  end

endmodule
